id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline register and operand forwarding stage for the CPE-CPU integer core; it sits directly upstream of the ALU. It captures one decoded instruction per clock and holds it on stall or kills it on flush. It resolves RAW hazards by forwarding results from the MEM and WB stages, then drives the ALU operand and control inputs. It also screens the 4-bit ALU control for unsupported encodings.

## Interface
- XLEN, 32, datapath width
- REG_ADDR_W, 5, register index width
- clk_w_i  in  1  core clock, all state updates on rising edge
- rst_w_i_h  in  1  reset, asynchronous, active-high
- id_valid_w_i_h  in  1  decode slot holds a real instruction
- id_rs1_data_w_i / id_rs2_data_w_i  in  XLEN  register-file read data
- id_rs1_addr_w_i / id_rs2_addr_w_i / id_rd_addr_w_i  in  REG_ADDR_W  source/destination indices
- id_imm_w_i  in  XLEN  sign-extended immediate
- id_alu_src_imm_w_i_h  in  1  B operand comes from immediate
- id_alu_control_w_i  in  4  ALU operation
- id_reg_write_w_i_h  in  1  instruction writes rd
- stall_w_i_h / flush_w_i_h  in  1  hazard-unit hold / kill
- mem_reg_write_w_i_h, mem_rd_addr_w_i, mem_rd_data_w_i  in  1/REG_ADDR_W/XLEN  MEM-stage writeback source
- wb_reg_write_w_i_h, wb_rd_addr_w_i, wb_rd_data_w_i  in  1/REG_ADDR_W/XLEN  WB-stage writeback source
- a_data_w_o / b_data_w_o  out  XLEN  ALU operands
- alu_control_w_o  out  4  ALU operation
- ex_rs2_data_w_o  out  XLEN  forwarded rs2 (store data), independent of immediate select
- ex_valid_w_o_h, ex_reg_write_w_o_h, illegal_op_w_o_h  out  1  EX slot status
- ex_rd_addr_w_o  out  REG_ADDR_W  destination index

## Operation
- Registered fields: valid, rs1/rs2 data and addr, rd, imm, alu_src_imm, alu_control, reg_write, illegal.
- Per-edge priority: reset > flush > stall > load.
  - Flush: valid=0, reg_write=0, alu_control=0000, illegal=0; the other fields are don't-care but are zeroed.
  - Stall (no flush): every register holds.
  - Load: capture all id_* inputs.
- Legal ALU codes: 0000 ADD, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 0110 OR, 0111 AND, 1000 SUB, 1101 SRA.
- Any other code loaded with id_valid=1 sets illegal=1, forces alu_control=0000 and forces reg_write=0. Valid stays 1 so the trap logic sees it.
- ex_reg_write_w_o_h = reg_write & valid.
- Forwarding is combinational from the registered operands, evaluated independently per source:
  - If mem_reg_write=1, mem_rd≠0 and mem_rd==rs, use mem_rd_data.
  - Else, if wb_reg_write=1, wb_rd≠0 and wb_rd==rs, use wb_rd_data.
  - Else use the registered data.
  - MEM has priority over WB.
  - Register x0 is never forwarded; its value is the registered data (0 from the register file).
- a_data = fwd(rs1). b_data = alu_src_imm ? imm : fwd(rs2). ex_rs2_data = fwd(rs2) always.
- Forwarding is re-evaluated every cycle during stall, so a held instruction picks up results that arrive while it waits.

## Timing
- Latency: id_* sampled at edge N, visible on outputs after edge N (one cycle).
- Forward path: mem/wb inputs to a/b outputs is purely combinational, with zero cycles of latency.
- Reset (asynchronous assert, synchronous release): all registers 0. Outputs therefore read a=b=0, alu_control=0000, valid=0, reg_write=0, illegal=0, rd=0.
- Reset mid-stall or mid-flush: reset wins immediately, without waiting for a clock edge.
- Simultaneous stall and flush: flush wins.
- id_valid=0 while loading: captured as a bubble (valid=0; reg_write is gated off at the output).
- MEM and WB both targeting the same rs: the MEM value is used.

## Structure
- Shared package cpu_pkg holds:
  - ALU_ADD..ALU_SRA 4-bit localparams, shared with the ALU.
  - XLEN and REG_ADDR_W defaults.
  - An alu_code_legal function.
- Sub-module fwd_mux: one instance per source operand. Inputs are rs addr, rs data and both writeback ports; output is the selected XLEN value.

## Test plan
- Reset asserted mid-load with id_valid=1, ADD, rs1 data=0x5 → all outputs 0 asynchronously; after release with stall=0, next edge loads normally.
- Load ADD with rs1=3 (data 0x10) and imm select, imm=0xFFFFFFFC; no forwarding → a=0x10, b=0xFFFFFFFC, alu_control=0000, valid=1 one cycle later.
- rs1=5, rs2=5; MEM writes x5=0xAAAA0000 and WB writes x5=0x1234 in the same cycle → a=b=0xAAAA0000; with MEM dropped → a=b=0x1234; with rs=0 and MEM writing x0 → registered value retained.
- Stall for 3 cycles with new id_* inputs changing; WB writes rs2 on cycle 2 → registers hold the original instruction, b switches to the WB data on cycle 2.
- stall=1 and flush=1 together on a valid SUB → next cycle valid=0, ex_reg_write=0, alu_control=0000.
- Sweep all 16 alu_control codes with id_valid=1, reg_write=1 → illegal=1 only for 1001–1100 and 1110–1111, and for those alu_control_w_o=0000 and ex_reg_write=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the CPE-CPU integer core.
//   - XLEN / REG_ADDR_W defaults for the datapath and register index widths
//   - ALU_* 4-bit operation codes, shared by the decode, ID/EX and ALU blocks
//   - alu_code_legal(): 1 when a 4-bit ALU code is implemented by the ALU
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    function automatic logic alu_code_legal(input logic [3:0] code);
        case (code)
            ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
            ALU_SRL, ALU_OR, ALU_AND, ALU_SUB, ALU_SRA: alu_code_legal = 1'b1;
            default:                                    alu_code_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: per-operand RAW forwarding select.
//   rs_addr/rs_data   registered source index and register-file data
//   mem_* / wb_*      writeback ports of the MEM and WB stages
//   fwd_data          selected operand value (MEM > WB > registered)
// x0 is never forwarded so it always reads the register-file value.
module fwd_mux
    import cpu_pkg::*;
#(
    parameter int XLEN_P       = XLEN,
    parameter int REG_ADDR_W_P = REG_ADDR_W
) (
    input  logic [REG_ADDR_W_P-1:0] rs_addr,
    input  logic [XLEN_P-1:0]       rs_data,
    input  logic                    mem_reg_write,
    input  logic [REG_ADDR_W_P-1:0] mem_rd_addr,
    input  logic [XLEN_P-1:0]       mem_rd_data,
    input  logic                    wb_reg_write,
    input  logic [REG_ADDR_W_P-1:0] wb_rd_addr,
    input  logic [XLEN_P-1:0]       wb_rd_data,
    output logic [XLEN_P-1:0]       fwd_data
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == rs_addr);
    assign wb_hit  = wb_reg_write  && (wb_rd_addr  != '0) && (wb_rd_addr  == rs_addr);

    always_comb begin
        fwd_data = rs_data;
        if (mem_hit)     fwd_data = mem_rd_data;
        else if (wb_hit) fwd_data = wb_rd_data;
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register plus operand forwarding, feeding the ALU.
//   clk_w_i, rst_w_i_h          clock, async active-high reset
//   id_*                        decoded instruction captured each edge
//   stall_w_i_h / flush_w_i_h   hold / kill the captured instruction (flush wins)
//   mem_* / wb_*                writeback sources for forwarding (combinational)
//   a_data_w_o / b_data_w_o     ALU operands; b selects imm when alu_src_imm
//   ex_rs2_data_w_o             forwarded rs2 for stores, ignores imm select
//   alu_control_w_o, ex_*       EX slot control and status
// Illegal ALU codes are neutralised at capture: op forced to ADD, no write,
// but the slot stays valid so trap logic downstream can act on it.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int XLEN_P       = XLEN,
    parameter int REG_ADDR_W_P = REG_ADDR_W
) (
    input  logic                    clk_w_i,
    input  logic                    rst_w_i_h,
    input  logic                    id_valid_w_i_h,
    input  logic [XLEN_P-1:0]       id_rs1_data_w_i,
    input  logic [XLEN_P-1:0]       id_rs2_data_w_i,
    input  logic [REG_ADDR_W_P-1:0] id_rs1_addr_w_i,
    input  logic [REG_ADDR_W_P-1:0] id_rs2_addr_w_i,
    input  logic [REG_ADDR_W_P-1:0] id_rd_addr_w_i,
    input  logic [XLEN_P-1:0]       id_imm_w_i,
    input  logic                    id_alu_src_imm_w_i_h,
    input  logic [3:0]              id_alu_control_w_i,
    input  logic                    id_reg_write_w_i_h,
    input  logic                    stall_w_i_h,
    input  logic                    flush_w_i_h,
    input  logic                    mem_reg_write_w_i_h,
    input  logic [REG_ADDR_W_P-1:0] mem_rd_addr_w_i,
    input  logic [XLEN_P-1:0]       mem_rd_data_w_i,
    input  logic                    wb_reg_write_w_i_h,
    input  logic [REG_ADDR_W_P-1:0] wb_rd_addr_w_i,
    input  logic [XLEN_P-1:0]       wb_rd_data_w_i,
    output logic [XLEN_P-1:0]       a_data_w_o,
    output logic [XLEN_P-1:0]       b_data_w_o,
    output logic [3:0]              alu_control_w_o,
    output logic [XLEN_P-1:0]       ex_rs2_data_w_o,
    output logic                    ex_valid_w_o_h,
    output logic                    ex_reg_write_w_o_h,
    output logic                    illegal_op_w_o_h,
    output logic [REG_ADDR_W_P-1:0] ex_rd_addr_w_o
);

    localparam int NUM_SRC = 2;  // index 0 = rs1, 1 = rs2

    logic                    valid_q;
    logic [XLEN_P-1:0]       rs1_data_q, rs2_data_q, imm_q;
    logic [REG_ADDR_W_P-1:0] rs1_addr_q, rs2_addr_q, rd_addr_q;
    logic                    alu_src_imm_q;
    logic [3:0]              alu_control_q;
    logic                    reg_write_q;
    logic                    illegal_q;

    logic id_illegal;
    assign id_illegal = id_valid_w_i_h && !alu_code_legal(id_alu_control_w_i);

    always_ff @(posedge clk_w_i or posedge rst_w_i_h) begin
        if (rst_w_i_h || flush_w_i_h) begin
            // Reset is the async term; flush reaches here only on a clock edge.
            valid_q       <= 1'b0;
            rs1_data_q    <= '0;
            rs2_data_q    <= '0;
            rs1_addr_q    <= '0;
            rs2_addr_q    <= '0;
            rd_addr_q     <= '0;
            imm_q         <= '0;
            alu_src_imm_q <= 1'b0;
            alu_control_q <= ALU_ADD;
            reg_write_q   <= 1'b0;
            illegal_q     <= 1'b0;
        end else if (!stall_w_i_h) begin
            valid_q       <= id_valid_w_i_h;
            rs1_data_q    <= id_rs1_data_w_i;
            rs2_data_q    <= id_rs2_data_w_i;
            rs1_addr_q    <= id_rs1_addr_w_i;
            rs2_addr_q    <= id_rs2_addr_w_i;
            rd_addr_q     <= id_rd_addr_w_i;
            imm_q         <= id_imm_w_i;
            alu_src_imm_q <= id_alu_src_imm_w_i_h;
            alu_control_q <= id_illegal ? ALU_ADD : id_alu_control_w_i;
            reg_write_q   <= id_reg_write_w_i_h && !id_illegal;
            illegal_q     <= id_illegal;
        end
    end

    logic [NUM_SRC-1:0][REG_ADDR_W_P-1:0] src_addr;
    logic [NUM_SRC-1:0][XLEN_P-1:0]       src_data;
    logic [NUM_SRC-1:0][XLEN_P-1:0]       src_fwd;

    assign src_addr = {rs2_addr_q, rs1_addr_q};
    assign src_data = {rs2_data_q, rs1_data_q};

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_fwd
        fwd_mux #(
            .XLEN_P       (XLEN_P),
            .REG_ADDR_W_P (REG_ADDR_W_P)
        ) u_fwd_mux (
            .rs_addr       (src_addr[s]),
            .rs_data       (src_data[s]),
            .mem_reg_write (mem_reg_write_w_i_h),
            .mem_rd_addr   (mem_rd_addr_w_i),
            .mem_rd_data   (mem_rd_data_w_i),
            .wb_reg_write  (wb_reg_write_w_i_h),
            .wb_rd_addr    (wb_rd_addr_w_i),
            .wb_rd_data    (wb_rd_data_w_i),
            .fwd_data      (src_fwd[s])
        );
    end

    assign a_data_w_o         = src_fwd[0];
    assign b_data_w_o         = alu_src_imm_q ? imm_q : src_fwd[1];
    assign ex_rs2_data_w_o    = src_fwd[1];
    assign alu_control_w_o    = alu_control_q;
    assign ex_valid_w_o_h     = valid_q;
    assign ex_reg_write_w_o_h = reg_write_q && valid_q;
    assign illegal_op_w_o_h   = illegal_q;
    assign ex_rd_addr_w_o     = rd_addr_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        id_alu_src_imm;
    logic [3:0]  id_alu_control;
    logic        id_reg_write;
    logic        stall, flush;
    logic        mem_we, wb_we;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_data, wb_data;
    logic [31:0] a_data, b_data, ex_rs2_data;
    logic [3:0]  alu_control;
    logic        ex_valid, ex_reg_write, illegal_op;
    logic [4:0]  ex_rd;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk_w_i              (clk),
        .rst_w_i_h            (rst),
        .id_valid_w_i_h       (id_valid),
        .id_rs1_data_w_i      (id_rs1_data),
        .id_rs2_data_w_i      (id_rs2_data),
        .id_rs1_addr_w_i      (id_rs1_addr),
        .id_rs2_addr_w_i      (id_rs2_addr),
        .id_rd_addr_w_i       (id_rd_addr),
        .id_imm_w_i           (id_imm),
        .id_alu_src_imm_w_i_h (id_alu_src_imm),
        .id_alu_control_w_i   (id_alu_control),
        .id_reg_write_w_i_h   (id_reg_write),
        .stall_w_i_h          (stall),
        .flush_w_i_h          (flush),
        .mem_reg_write_w_i_h  (mem_we),
        .mem_rd_addr_w_i      (mem_rd),
        .mem_rd_data_w_i      (mem_data),
        .wb_reg_write_w_i_h   (wb_we),
        .wb_rd_addr_w_i       (wb_rd),
        .wb_rd_data_w_i       (wb_data),
        .a_data_w_o           (a_data),
        .b_data_w_o           (b_data),
        .alu_control_w_o      (alu_control),
        .ex_rs2_data_w_o      (ex_rs2_data),
        .ex_valid_w_o_h       (ex_valid),
        .ex_reg_write_w_o_h   (ex_reg_write),
        .illegal_op_w_o_h     (illegal_op),
        .ex_rd_addr_w_o       (ex_rd)
    );

    // Drive an instruction onto the decode inputs (no checking here).
    task automatic set_id(input logic v, input logic [4:0] r1, input logic [31:0] d1,
                          input logic [4:0] r2, input logic [31:0] d2, input logic [4:0] rd,
                          input logic [31:0] imm, input logic use_imm, input logic [3:0] op,
                          input logic we);
        id_valid = v; id_rs1_addr = r1; id_rs1_data = d1; id_rs2_addr = r2;
        id_rs2_data = d2; id_rd_addr = rd; id_imm = imm; id_alu_src_imm = use_imm;
        id_alu_control = op; id_reg_write = we;
    endtask

    task automatic idle_wb();
        mem_we = 1'b0; mem_rd = '0; mem_data = '0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    endtask

    // Advance one edge and settle 1ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0; idle_wb();
        set_id(1'b1, 5'd1, 32'h5, 5'd2, 32'h7, 5'd4, 32'h0, 1'b0, 4'b0000, 1'b1);
        #1;
        checks++;
        if (a_data !== 0 || b_data !== 0 || alu_control !== 0 || ex_valid !== 0 ||
            ex_reg_write !== 0 || illegal_op !== 0 || ex_rd !== 0) begin
            failures++;
            $display("FAIL reset_state: a=%h b=%h op=%b v=%b we=%b ill=%b rd=%0d expected all 0",
                     a_data, b_data, alu_control, ex_valid, ex_reg_write, illegal_op, ex_rd);
        end
        tick();
        checks++;
        if (ex_valid !== 0 || a_data !== 0) begin
            failures++;
            $display("FAIL reset_hold: v=%b a=%h expected 0/0", ex_valid, a_data);
        end
        @(negedge clk); rst = 1'b0;
        tick();
        checks++;
        if (a_data !== 32'h5 || ex_valid !== 1'b1 || ex_reg_write !== 1'b1 || ex_rd !== 5'd4) begin
            failures++;
            $display("FAIL reset_release_load: a=%h v=%b we=%b rd=%0d expected 5/1/1/4",
                     a_data, ex_valid, ex_reg_write, ex_rd);
        end
        // Mid-cycle reset must clear outputs with no clock edge.
        #2; rst = 1'b1; #1;
        checks++;
        if (a_data !== 0 || ex_valid !== 0 || ex_reg_write !== 0 || ex_rd !== 0) begin
            failures++;
            $display("FAIL reset_async: a=%h v=%b we=%b rd=%0d expected 0", a_data, ex_valid,
                     ex_reg_write, ex_rd);
        end
        @(negedge clk); rst = 1'b0;
        tick();
        // Reset while stalled also wins immediately.
        stall = 1'b1; #2; rst = 1'b1; #1;
        checks++;
        if (a_data !== 0 || ex_valid !== 0 || alu_control !== 0) begin
            failures++;
            $display("FAIL reset_mid_stall: a=%h v=%b op=%b expected 0", a_data, ex_valid,
                     alu_control);
        end
        @(negedge clk); rst = 1'b0; stall = 1'b0;
    endtask

    task automatic test_load_imm();
        set_id(1'b1, 5'd3, 32'h10, 5'd4, 32'h22, 5'd7, 32'hFFFF_FFFC, 1'b1, 4'b0000, 1'b1);
        tick();
        checks++;
        if (a_data !== 32'h10 || b_data !== 32'hFFFF_FFFC || alu_control !== 4'b0000 ||
            ex_valid !== 1'b1 || ex_reg_write !== 1'b1 || ex_rd !== 5'd7) begin
            failures++;
            $display("FAIL load_imm: a=%h b=%h op=%b v=%b we=%b rd=%0d expected 10/fffffffc/0000/1/1/7",
                     a_data, b_data, alu_control, ex_valid, ex_reg_write, ex_rd);
        end
        checks++;
        if (ex_rs2_data !== 32'h22 || illegal_op !== 1'b0) begin
            failures++;
            $display("FAIL load_imm_rs2: rs2=%h ill=%b expected 22/0", ex_rs2_data, illegal_op);
        end
    endtask

    task automatic test_forward();
        set_id(1'b1, 5'd5, 32'h11, 5'd5, 32'h22, 5'd6, 32'h0, 1'b0, 4'b0110, 1'b1);
        tick();
        stall = 1'b1;
        mem_we = 1'b1; mem_rd = 5'd5; mem_data = 32'hAAAA_0000;
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000_1234;
        #1;
        checks++;
        if (a_data !== 32'hAAAA_0000 || b_data !== 32'hAAAA_0000 || ex_rs2_data !== 32'hAAAA_0000) begin
            failures++;
            $display("FAIL fwd_mem_priority: a=%h b=%h rs2=%h expected aaaa0000", a_data, b_data,
                     ex_rs2_data);
        end
        mem_we = 1'b0; #1;
        checks++;
        if (a_data !== 32'h1234 || b_data !== 32'h1234) begin
            failures++;
            $display("FAIL fwd_wb: a=%h b=%h expected 1234", a_data, b_data);
        end
        wb_we = 1'b0; #1;
        checks++;
        if (a_data !== 32'h11 || b_data !== 32'h22) begin
            failures++;
            $display("FAIL fwd_none: a=%h b=%h expected 11/22", a_data, b_data);
        end
        mem_we = 1'b1; mem_rd = 5'd6; #1;
        checks++;
        if (a_data !== 32'h11) begin
            failures++;
            $display("FAIL fwd_addr_miss: a=%h expected 11", a_data);
        end
        idle_wb(); stall = 1'b0;
        set_id(1'b1, 5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 32'h0, 1'b0, 4'b0000, 1'b1);
        tick();
        mem_we = 1'b1; mem_rd = 5'd0; mem_data = 32'hDEAD_BEEF;
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hCAFE_F00D;
        #1;
        checks++;
        if (a_data !== 32'h0 || b_data !== 32'h0 || ex_rs2_data !== 32'h0) begin
            failures++;
            $display("FAIL fwd_x0: a=%h b=%h rs2=%h expected 0", a_data, b_data, ex_rs2_data);
        end
        idle_wb();
    endtask

    task automatic test_stall();
        set_id(1'b1, 5'd1, 32'h100, 5'd2, 32'h200, 5'd3, 32'h0, 1'b0, 4'b0100, 1'b1);
        tick();
        stall = 1'b1;
        set_id(1'b1, 5'd9, 32'h999, 5'd10, 32'hAAA, 5'd11, 32'h5, 1'b1, 4'b1000, 1'b0);
        tick();
        checks++;
        if (a_data !== 32'h100 || b_data !== 32'h200 || alu_control !== 4'b0100 || ex_rd !== 5'd3 ||
            ex_reg_write !== 1'b1) begin
            failures++;
            $display("FAIL stall_c1: a=%h b=%h op=%b rd=%0d we=%b expected 100/200/0100/3/1",
                     a_data, b_data, alu_control, ex_rd, ex_reg_write);
        end
        set_id(1'b0, 5'd12, 32'h777, 5'd13, 32'h888, 5'd14, 32'h6, 1'b0, 4'b0111, 1'b1);
        wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'h5555;
        tick();
        checks++;
        if (a_data !== 32'h100 || b_data !== 32'h5555 || ex_valid !== 1'b1 || ex_rd !== 5'd3) begin
            failures++;
            $display("FAIL stall_c2_wb: a=%h b=%h v=%b rd=%0d expected 100/5555/1/3",
                     a_data, b_data, ex_valid, ex_rd);
        end
        wb_we = 1'b0;
        set_id(1'b1, 5'd15, 32'h333, 5'd16, 32'h444, 5'd17, 32'h0, 1'b0, 4'b0001, 1'b1);
        tick();
        checks++;
        if (a_data !== 32'h100 || b_data !== 32'h200 || alu_control !== 4'b0100 || ex_rd !== 5'd3) begin
            failures++;
            $display("FAIL stall_c3: a=%h b=%h op=%b rd=%0d expected 100/200/0100/3",
                     a_data, b_data, alu_control, ex_rd);
        end
        stall = 1'b0;
    endtask

    task automatic test_stall_flush();
        set_id(1'b1, 5'd1, 32'h9, 5'd2, 32'h4, 5'd8, 32'h0, 1'b0, 4'b1000, 1'b1);
        tick();
        checks++;
        if (alu_control !== 4'b1000 || ex_valid !== 1'b1) begin
            failures++;
            $display("FAIL sub_load: op=%b v=%b expected 1000/1", alu_control, ex_valid);
        end
        stall = 1'b1; flush = 1'b1;
        tick();
        checks++;
        if (ex_valid !== 0 || ex_reg_write !== 0 || alu_control !== 0 || illegal_op !== 0 ||
            a_data !== 0 || ex_rd !== 0) begin
            failures++;
            $display("FAIL stall_flush: v=%b we=%b op=%b ill=%b a=%h rd=%0d expected 0",
                     ex_valid, ex_reg_write, alu_control, illegal_op, a_data, ex_rd);
        end
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_bubble();
        set_id(1'b0, 5'd1, 32'h1, 5'd2, 32'h2, 5'd9, 32'h0, 1'b0, 4'b1111, 1'b1);
        tick();
        checks++;
        if (ex_valid !== 0 || ex_reg_write !== 0 || illegal_op !== 0) begin
            failures++;
            $display("FAIL bubble: v=%b we=%b ill=%b expected 0/0/0", ex_valid, ex_reg_write,
                     illegal_op);
        end
    endtask

    task automatic test_alu_sweep();
        logic [15:0] illegal_mask;
        illegal_mask = 16'b1101_1110_0000_0000;  // codes 9..12, 14, 15
        for (int c = 0; c < 16; c++) begin
            set_id(1'b1, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 32'h0, 1'b0, 4'(c), 1'b1);
            tick();
            checks++;
            if (illegal_mask[c]) begin
                if (illegal_op !== 1'b1 || alu_control !== 4'b0000 || ex_reg_write !== 1'b0 ||
                    ex_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL alu_sweep_%0d: ill=%b op=%b we=%b v=%b expected 1/0000/0/1",
                             c, illegal_op, alu_control, ex_reg_write, ex_valid);
                end
            end else begin
                if (illegal_op !== 1'b0 || alu_control !== 4'(c) || ex_reg_write !== 1'b1 ||
                    ex_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL alu_sweep_%0d: ill=%b op=%b we=%b v=%b expected 0/%b/1/1",
                             c, illegal_op, alu_control, ex_reg_write, ex_valid, 4'(c));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_imm();
        test_forward();
        test_stall();
        test_stall_flush();
        test_bubble();
        test_alu_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
